// File: rtl/ss_scan_driver.sv
// Multiplexed seven-segment scan driver: hex decode, per-digit DP/blank,
// leading-zero suppression, PWM brightness, anti-ghost blank interval and
// frame-synchronous shadowing of all display inputs. Pins are active low.
module ss_scan_driver #(
   parameter int unsigned NUM_DIGITS   = 4,
   parameter int unsigned DIV_BITS     = 17,
   parameter int unsigned BLANK_CYCLES = 256,
   parameter int unsigned PWM_BITS     = 8
) (
   input  logic                    Clk,
   input  logic                    Reset,
   input  logic [4*NUM_DIGITS-1:0] Digits,
   input  logic [NUM_DIGITS-1:0]   DP,
   input  logic [NUM_DIGITS-1:0]   Blank,
   input  logic                    LeadingZeroSuppress,
   input  logic [PWM_BITS-1:0]     Brightness,
   output logic [NUM_DIGITS-1:0]   SegmentDrivers,
   output logic [7:0]              SevenSegment,
   output logic                    FrameStart
);

   localparam int unsigned IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
   localparam int unsigned DIG_W = 4 * NUM_DIGITS;
   localparam logic [IDX_W-1:0]    LAST_IDX  = IDX_W'(NUM_DIGITS - 1);
   localparam logic [DIV_BITS-1:0] BLANK_END = DIV_BITS'(BLANK_CYCLES);

   // scan timing state
   logic [DIV_BITS-1:0]   r_dwell;
   logic [IDX_W-1:0]      r_idx;
   logic [PWM_BITS-1:0]   r_pwm;

   // frame-synchronous shadow copies of the display inputs
   logic [DIG_W-1:0]      r_digits_s;
   logic [NUM_DIGITS-1:0] r_dp_s;
   logic [NUM_DIGITS-1:0] r_blank_s;
   logic                  r_lzs_s;
   logic [PWM_BITS-1:0]   r_bright_s;
   logic                  r_frame_evt;

   logic                  w_load;
   logic                  w_wrap;
   logic [NUM_DIGITS-1:0] w_suppress;
   logic [NUM_DIGITS-1:0] w_blank_eff;
   logic                  w_seen_nz;
   logic [3:0]            w_nibble;
   logic [6:0]            w_seg_code;
   logic                  w_on_phase;
   logic                  w_duty;
   logic                  w_lit;

   assign w_load = (r_idx == '0) && (r_dwell == '0);
   assign w_wrap = &r_dwell;

   // dwell, digit index and PWM counters
   always_ff @(posedge Clk) begin
      if (Reset) begin
         r_dwell <= '0;
         r_idx   <= '0;
         r_pwm   <= '0;
      end else begin
         r_dwell <= r_dwell + DIV_BITS'(1);
         r_pwm   <= r_pwm + PWM_BITS'(1);
         if (w_wrap) begin
            r_idx <= (r_idx == LAST_IDX) ? '0 : r_idx + IDX_W'(1);
         end
      end
   end

   // capture inputs once per frame; blank everything until the first capture
   always_ff @(posedge Clk) begin
      if (Reset) begin
         r_digits_s  <= '0;
         r_dp_s      <= '0;
         r_blank_s   <= '1;
         r_lzs_s     <= 1'b0;
         r_bright_s  <= '0;
         r_frame_evt <= 1'b0;
      end else begin
         r_frame_evt <= w_load;
         if (w_load) begin
            r_digits_s <= Digits;
            r_dp_s     <= DP;
            r_blank_s  <= Blank;
            r_lzs_s    <= LeadingZeroSuppress;
            r_bright_s <= Brightness;
         end
      end
   end

   // leading zeros from the top digit down to digit 1 are suppressed
   always_comb begin
      w_suppress = '0;
      w_seen_nz  = 1'b0;
      for (int i = int'(NUM_DIGITS) - 1; i > 0; i--) begin
         if (r_digits_s[4*i +: 4] != 4'h0) begin
            w_seen_nz = 1'b1;
         end else if (!w_seen_nz && r_lzs_s) begin
            w_suppress[i] = 1'b1;
         end
      end
   end

   assign w_blank_eff = r_blank_s | w_suppress;
   assign w_nibble    = r_digits_s[{r_idx, 2'b00} +: 4];

   // hex to active-low {g,f,e,d,c,b,a}
   always_comb begin
      w_seg_code = 7'h7F;
      case (w_nibble)
         4'h0: w_seg_code = 7'h40;
         4'h1: w_seg_code = 7'h79;
         4'h2: w_seg_code = 7'h24;
         4'h3: w_seg_code = 7'h30;
         4'h4: w_seg_code = 7'h19;
         4'h5: w_seg_code = 7'h12;
         4'h6: w_seg_code = 7'h02;
         4'h7: w_seg_code = 7'h78;
         4'h8: w_seg_code = 7'h00;
         4'h9: w_seg_code = 7'h10;
         4'hA: w_seg_code = 7'h08;
         4'hB: w_seg_code = 7'h03;
         4'hC: w_seg_code = 7'h46;
         4'hD: w_seg_code = 7'h21;
         4'hE: w_seg_code = 7'h06;
         4'hF: w_seg_code = 7'h0E;
         default: w_seg_code = 7'h7F;
      endcase
   end

   // all-ones brightness is a true 100 % duty, otherwise compare against PWM
   assign w_on_phase = (r_dwell >= BLANK_END);
   assign w_duty     = (&r_bright_s) || (r_pwm < r_bright_s);
   assign w_lit      = w_on_phase && !w_blank_eff[r_idx] && w_duty;

   // registered pins: at most one driver low, everything dark when not lit
   always_ff @(posedge Clk) begin
      if (Reset) begin
         SegmentDrivers <= '1;
         SevenSegment   <= 8'hFF;
         FrameStart     <= 1'b0;
      end else begin
         FrameStart <= r_frame_evt;
         if (w_lit) begin
            SegmentDrivers <= ~(NUM_DIGITS'(1) << r_idx);
            SevenSegment   <= {~r_dp_s[r_idx], w_seg_code};
         end else begin
            SegmentDrivers <= '1;
            SevenSegment   <= 8'hFF;
         end
      end
   end

endmodule

// File: tb/tb_ss_scan_driver.sv
// Scoreboard bench for ss_scan_driver: a time-based reference model pushes
// the expected pins for every clock, a negedge monitor pops and compares.
module tb_ss_scan_driver;

   localparam int unsigned N       = 4;
   localparam int unsigned DIVB    = 4;
   localparam int unsigned BLK     = 2;
   localparam int unsigned PWMB    = 3;
   localparam int unsigned DWELL   = 1 << DIVB;
   localparam int unsigned FRAME   = N * DWELL;
   localparam int unsigned PWM_MOD = 1 << PWMB;

   logic             Clk = 1'b0;
   logic             Reset = 1'b1;
   logic [4*N-1:0]   Digits = '0;
   logic [N-1:0]     DP = '0;
   logic [N-1:0]     Blank = '0;
   logic             LeadingZeroSuppress = 1'b0;
   logic [PWMB-1:0]  Brightness = '0;
   logic [N-1:0]     SegmentDrivers;
   logic [7:0]       SevenSegment;
   logic             FrameStart;

   ss_scan_driver #(
      .NUM_DIGITS  (N),
      .DIV_BITS    (DIVB),
      .BLANK_CYCLES(BLK),
      .PWM_BITS    (PWMB)
   ) dut (
      .Clk                (Clk),
      .Reset              (Reset),
      .Digits             (Digits),
      .DP                 (DP),
      .Blank              (Blank),
      .LeadingZeroSuppress(LeadingZeroSuppress),
      .Brightness         (Brightness),
      .SegmentDrivers     (SegmentDrivers),
      .SevenSegment       (SevenSegment),
      .FrameStart         (FrameStart)
   );

   always #5 Clk = ~Clk;

   typedef struct packed {
      logic [N-1:0] drv;
      logic [7:0]   seg;
      logic         fs;
   } exp_t;

   exp_t sb[$];
   int   checks = 0;
   int   errors = 0;

   // model state: clocks since reset release, and the frame's captured inputs
   int unsigned      k = 0;
   logic [4*N-1:0]   s_digits = '0;
   logic [N-1:0]     s_dp = '0;
   logic [N-1:0]     s_blank = '1;
   logic             s_lzs = 1'b0;
   logic [PWMB-1:0]  s_bright = '0;

   logic [6:0] seg_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

   // expected pins after the clock that follows internal time m
   function automatic exp_t expect_at(input int unsigned m);
      exp_t        e;
      int unsigned dwell;
      int unsigned idx;
      int unsigned pwm;
      logic [N-1:0] hidden;
      logic [3:0]  nib;
      bit          lit;
      dwell  = m % DWELL;
      idx    = (m / DWELL) % N;
      pwm    = m % PWM_MOD;
      hidden = s_blank;
      if (s_lzs) begin
         for (int d = int'(N) - 1; d >= 1; d--) begin
            if (s_digits[4*d +: 4] != 4'h0) break;
            hidden[d] = 1'b1;
         end
      end
      lit = (dwell >= BLK) && !hidden[idx] &&
            ((s_bright == PWMB'(PWM_MOD - 1)) || (pwm < int'(s_bright)));
      nib = s_digits[4*idx +: 4];
      e.fs = ((m % FRAME) == 1);
      if (lit) begin
         e.drv      = '1;
         e.drv[idx] = 1'b0;
         e.seg      = {~s_dp[idx], seg_tab[nib]};
      end else begin
         e.drv = '1;
         e.seg = 8'hFF;
      end
      return e;
   endfunction

   // advance the model by one clock edge using the inputs sampled there
   task automatic model_edge();
      exp_t e;
      if (Reset) begin
         k       = 0;
         s_blank = '1;
         e.drv   = '1;
         e.seg   = 8'hFF;
         e.fs    = 1'b0;
      end else begin
         k = k + 1;
         e = expect_at(k - 1);
         if (((k - 1) % FRAME) == 0) begin
            s_digits = Digits;
            s_dp     = DP;
            s_blank  = Blank;
            s_lzs    = LeadingZeroSuppress;
            s_bright = Brightness;
         end
      end
      sb.push_back(e);
   endtask

   task automatic run_cycles(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge Clk);
         model_edge();
         #1;
      end
   endtask

   task automatic check(input string name, input logic [7:0] act, input logic [7:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s at %0t: got %h expected %h", name, $time, act, req);
      end
   endtask

   // monitor: compare pins against the scoreboard away from the active edge
   initial begin
      exp_t e;
      forever begin
         @(negedge Clk);
         if (sb.size() > 0) begin
            e = sb.pop_front();
            check("drivers", 8'(SegmentDrivers), 8'(e.drv));
            check("segments", SevenSegment, e.seg);
            check("framestart", 8'(FrameStart), 8'(e.fs));
         end
      end
   end

   task automatic set_in(input logic [15:0] dg, input logic [3:0] dp, input logic [3:0] bl,
                         input logic lzs, input logic [2:0] br);
      Digits              = dg;
      DP                  = dp;
      Blank               = bl;
      LeadingZeroSuppress = lzs;
      Brightness          = br;
   endtask

   initial begin
      logic [15:0] rd;
      set_in(16'h1A80, 4'b0000, 4'b0000, 1'b0, 3'd7);
      Reset = 1'b1;
      run_cycles(5);
      Reset = 1'b0;
      run_cycles(2 * FRAME);
      Brightness = 3'd3;
      run_cycles(2 * FRAME);
      Brightness = 3'd0;
      run_cycles(3 * FRAME);
      set_in(16'h0050, 4'b0000, 4'b0000, 1'b1, 3'd7);
      run_cycles(2 * FRAME);
      Digits = 16'h0000;
      run_cycles(2 * FRAME);
      set_in(16'h1234, 4'b0010, 4'b0100, 1'b0, 3'd7);
      run_cycles(FRAME + 20);
      Digits = 16'hBEEF;
      run_cycles(FRAME);

      // randomized inputs changing mid-frame, with occasional mid-scan resets
      for (int it = 0; it < 60; it++) begin
         for (int d = 0; d < 4; d++) begin
            rd[4*d +: 4] = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(0, 15));
         end
         set_in(rd, 4'($urandom), 4'($urandom_range(0, 3) == 0 ? $urandom : 0),
                1'($urandom), ($urandom_range(0, 2) == 0) ? 3'd7 : 3'($urandom));
         run_cycles(int'($urandom_range(1, 40)));
         if ($urandom_range(0, 9) == 0) begin
            Reset = 1'b1;
            run_cycles(int'($urandom_range(1, 3)));
            Reset = 1'b0;
         end
      end
      run_cycles(2);

      @(negedge Clk);
      #1;
      checks++;
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
